// File: rtl/imm_ext_unit.sv
// imm_ext_unit: buffered immediate extender (sign / zero / sign-shift-1)
// with a 2-entry output FIFO between decode and the ALU operand mux.
// Optional accepted-transaction counter: define IMMEXT_STATS_EN.
module imm_ext_unit #(
  parameter int IN_W     = 6,
  parameter int NARROW_W = 4,
  parameter int OUT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  data_in,
  input  logic             field_sel,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] data_out,
  output logic             out_err,
  output logic [15:0]      stat_count
);

  typedef enum logic [1:0] {
    MODE_SIGN  = 2'b00,
    MODE_ZERO  = 2'b01,
    MODE_SHIFT = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_t;

  logic [OUT_W-1:0] buf_data [2];
  logic [1:0]       buf_err;
  logic             head;
  logic             tail;
  logic [1:0]       count;

  logic             push;
  logic             pop;

  logic [OUT_W-1:0] sext_full;
  logic [OUT_W-1:0] sext_narrow;
  logic [OUT_W-1:0] zext_full;
  logic [OUT_W-1:0] zext_narrow;
  logic [OUT_W-1:0] ext_sign;
  logic [OUT_W-1:0] ext_zero;
  logic [OUT_W-1:0] ext_data;
  logic             ext_err;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign data_out  = buf_data[head];
  assign out_err   = buf_err[head];

  assign sext_full   = {{(OUT_W-IN_W){data_in[IN_W-1]}}, data_in};
  assign sext_narrow = {{(OUT_W-NARROW_W){data_in[NARROW_W-1]}}, data_in[NARROW_W-1:0]};
  assign zext_full   = {{(OUT_W-IN_W){1'b0}}, data_in};
  assign zext_narrow = {{(OUT_W-NARROW_W){1'b0}}, data_in[NARROW_W-1:0]};
  assign ext_sign    = field_sel ? sext_full : sext_narrow;
  assign ext_zero    = field_sel ? zext_full : zext_narrow;

  // Extension result for the entry being pushed this cycle
  always_comb begin
    ext_data = '0;
    ext_err  = 1'b0;
    case (mode_t'(mode))
      MODE_SIGN:  ext_data = ext_sign;
      MODE_ZERO:  ext_data = ext_zero;
      MODE_SHIFT: ext_data = {ext_sign[OUT_W-2:0], 1'b0};
      MODE_RSVD:  ext_err  = 1'b1;
    endcase
  end

  // FIFO pointers, occupancy and entry storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
      end
      buf_err <= '0;
    end else begin
      if (push) begin
        buf_data[tail] <= ext_data;
        buf_err[tail]  <= ext_err;
        tail           <= ~tail;
      end
      // Draining the last entry copies it into the slot the head moves to,
      // so data_out/out_err keep showing the last value while empty.
      if (pop && !push && count == 2'd1) begin
        buf_data[~head] <= buf_data[head];
        buf_err[~head]  <= buf_err[head];
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef IMMEXT_STATS_EN
  logic [15:0] stat_q;

  // Saturating count of accepted pushes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_q <= '0;
    end else if (push && stat_q != '1) begin
      stat_q <= stat_q + 16'd1;
    end
  end

  assign stat_count = stat_q;
`else
  assign stat_count = '0;
`endif

endmodule
